jk_excitation_driver: RTL and testbench

- Reverse direction of the JK flip-flop: accepts a desired next-state word and derives per-bit J/K excitation against the current state of a WIDTH-bit JK flip-flop bank.
- Drives the derived J/K for one clock, reads back the bank's Q, and reports success or mismatch, with bounded retry.
- Sits between control logic that issues target words and a bank of jk_flip_flop instances that share clk.

---
 rtl/jk_excitation_driver.sv | 124 ++++++++++++
 tb/tb_jk_excitation_driver.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// Derives per-bit J/K excitation that moves a JK flip-flop bank to a target word,
// applies it for one clock, reads the bank back and retries a bounded number of times.
module jk_excitation_driver #(
  parameter int WIDTH     = 8,
  parameter int DC_MODE   = 0,
  parameter int MAX_RETRY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tgt_valid,
  output logic                       tgt_ready,
  input  logic [WIDTH-1:0]           tgt_data,
  input  logic [WIDTH-1:0]           q_fb,
  output logic [WIDTH-1:0]           J,
  output logic [WIDTH-1:0]           K,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(WIDTH+1)-1:0] chg_cnt
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    APPLY,
    CHECK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] j_calc;
  logic [WIDTH-1:0] k_calc;
  logic [WIDTH-1:0] diff;
  logic [CW-1:0]    pop;
  logic [2:0]       retry;
  logic             match;
  logic             retry_ok;

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign diff      = tgt_r ^ q_fb;
  assign match     = (diff == '0);
  assign retry_ok  = (retry < 3'(MAX_RETRY));

  // x-resolution of the JK excitation table
  always_comb begin
    j_calc = '0;
    k_calc = '0;
    if (DC_MODE == 0) begin
      j_calc = ~q_fb & tgt_r;
      k_calc = q_fb & ~tgt_r;
    end else begin
      j_calc = q_fb | tgt_r;
      k_calc = ~(q_fb & tgt_r);
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++)
      pop = pop + CW'(diff[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (tgt_valid) state_nxt = CALC;
      CALC:  state_nxt = APPLY;
      APPLY: state_nxt = CHECK;
      CHECK: begin
        if (match)         state_nxt = IDLE;
        else if (retry_ok) state_nxt = CALC;
        else               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      J       <= '0;
      K       <= '0;
      tgt_r   <= '0;
      retry   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      chg_cnt <= '0;
    end else begin
      J    <= '0;
      K    <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt_r <= tgt_data;
            retry <= '0;
          end
        end
        CALC: begin
          J <= j_calc;
          K <= k_calc;
          if (retry == '0) chg_cnt <= pop;
        end
        APPLY: ;
        CHECK: begin
          if (match)         done  <= 1'b1;
          else if (retry_ok) retry <= retry + 3'd1;
          else               err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (toggle-free and toggle-preferred)
// each driving a behavioural JK bank; outcomes are scored against a queue.
module tb_jk_excitation_driver;

  typedef struct packed {
    logic       is_err;
    logic [7:0] bank;
    logic [3:0] chg;
    logic [7:0] lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       rdy0, rdy1, busy0, busy1;
  logic       done0, done1, err0, err1;
  logic [7:0] J0, K0, J1, K1;
  logic [3:0] chg0, chg1;

  logic [7:0] bank0 = '0, bank1 = '0;
  logic [7:0] init0 = '0, init1 = '0;
  logic       ld0 = 1'b0, ld1 = 1'b0;
  logic [7:0] stuck0 = '0;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(8), .DC_MODE(0), .MAX_RETRY(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .tgt_valid(v0), .tgt_ready(rdy0), .tgt_data(d0),
    .q_fb(bank0), .J(J0), .K(K0),
    .busy(busy0), .done(done0), .err(err0), .chg_cnt(chg0)
  );

  jk_excitation_driver #(.WIDTH(8), .DC_MODE(1), .MAX_RETRY(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .tgt_valid(v1), .tgt_ready(rdy1), .tgt_data(d1),
    .q_fb(bank1), .J(J1), .K(K1),
    .busy(busy1), .done(done1), .err(err1), .chg_cnt(chg1)
  );

  // Behavioural JK banks: Q+ = J~Q | ~KQ, optional stuck-at-0 bits
  always @(posedge clk) begin
    if (ld0) bank0 <= init0;
    else     bank0 <= ((J0 & ~bank0) | (~K0 & bank0)) & ~stuck0;
    if (ld1) bank1 <= init1;
    else     bank1 <= (J1 & ~bank1) | (~K1 & bank1);
  end

  task automatic load_bank(input bit sel, input logic [7:0] val);
    @(negedge clk);
    if (sel) begin init1 = val; ld1 = 1'b1; end
    else     begin init0 = val; ld0 = 1'b1; end
    @(negedge clk);
    ld0 = 1'b0;
    ld1 = 1'b0;
  endtask

  // Observes one transaction; cycle 0 is the negedge where valid was driven
  task automatic wait_out(input bit sel, input bit hold, output int cyc,
                          output logic [7:0] jap, output logic [7:0] kap,
                          output int npl);
    cyc = 0;
    jap = '0;
    kap = '0;
    npl = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!hold) begin
        if (sel) v1 = 1'b0;
        else     v0 = 1'b0;
      end
      if (cyc == 2) begin
        jap = sel ? J1 : J0;
        kap = sel ? K1 : K0;
      end
      if (((sel ? J1 : J0) | (sel ? K1 : K0)) != 8'h00) npl++;
    end while (!(sel ? (done1 | err1) : (done0 | err0)) && cyc < 24);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({J0, K0} !== 16'h0) begin
      errors++; $display("FAIL reset_jk: got %h want 0000", {J0, K0});
    end
    checks++;
    if ({busy0, done0, err0, chg0} !== 7'h0) begin
      errors++; $display("FAIL reset_flags: got %b want 0", {busy0, done0, err0, chg0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy0, rdy1, busy0, busy1} !== 4'b1100) begin
      errors++; $display("FAIL reset_ready: got %b want 1100", {rdy0, rdy1, busy0, busy1});
    end
  endtask

  task automatic test_set_a5();
    int cyc, npl; logic [7:0] jap, kap; exp_t e;
    load_bank(0, 8'h00);
    sb.push_back({1'b0, 8'hA5, 4'd4, 8'd4});
    v0 = 1'b1; d0 = 8'hA5;
    wait_out(0, 0, cyc, jap, kap, npl);
    e = sb.pop_front();
    checks++;
    if ({jap, kap} !== 16'hA500) begin
      errors++; $display("FAIL a5_jk: got J=%h K=%h want J=a5 K=00", jap, kap);
    end
    checks++;
    if (cyc !== int'(e.lat) || {done0, err0} !== {~e.is_err, e.is_err}) begin
      errors++; $display("FAIL a5_done: got cyc=%0d d/e=%b%b want cyc=%0d", cyc, done0, err0, e.lat);
    end
    checks++;
    if (chg0 !== e.chg || bank0 !== e.bank) begin
      errors++; $display("FAIL a5_result: got chg=%0d bank=%h want chg=%0d bank=%h", chg0, bank0, e.chg, e.bank);
    end
  endtask

  task automatic test_mixed_dc0();
    int cyc, npl; logic [7:0] jap, kap; exp_t e;
    load_bank(0, 8'hF0);
    sb.push_back({1'b0, 8'h3C, 4'd4, 8'd4});
    v0 = 1'b1; d0 = 8'h3C;
    wait_out(0, 0, cyc, jap, kap, npl);
    e = sb.pop_front();
    checks++;
    if ({jap, kap} !== 16'h0CC0) begin
      errors++; $display("FAIL mix0_jk: got J=%h K=%h want J=0c K=c0", jap, kap);
    end
    checks++;
    if (cyc !== int'(e.lat) || {done0, err0} !== {~e.is_err, e.is_err}) begin
      errors++; $display("FAIL mix0_done: got cyc=%0d d/e=%b%b want cyc=%0d", cyc, done0, err0, e.lat);
    end
    checks++;
    if (chg0 !== e.chg || bank0 !== e.bank) begin
      errors++; $display("FAIL mix0_result: got chg=%0d bank=%h want chg=%0d bank=%h", chg0, bank0, e.chg, e.bank);
    end
  endtask

  task automatic test_mixed_dc1();
    int cyc, npl; logic [7:0] jap, kap; exp_t e;
    load_bank(1, 8'hF0);
    sb.push_back({1'b0, 8'h3C, 4'd4, 8'd4});
    v1 = 1'b1; d1 = 8'h3C;
    wait_out(1, 0, cyc, jap, kap, npl);
    e = sb.pop_front();
    checks++;
    if ({jap, kap} !== 16'hFCCF) begin
      errors++; $display("FAIL mix1_jk: got J=%h K=%h want J=fc K=cf", jap, kap);
    end
    checks++;
    if (cyc !== int'(e.lat) || {done1, err1} !== {~e.is_err, e.is_err}) begin
      errors++; $display("FAIL mix1_done: got cyc=%0d d/e=%b%b want cyc=%0d", cyc, done1, err1, e.lat);
    end
    checks++;
    if (chg1 !== e.chg || bank1 !== e.bank) begin
      errors++; $display("FAIL mix1_result: got chg=%0d bank=%h want chg=%0d bank=%h", chg1, bank1, e.chg, e.bank);
    end
  endtask

  task automatic test_same_word();
    int cyc, npl; logic [7:0] jap, kap; exp_t e;
    load_bank(0, 8'h5A);
    sb.push_back({1'b0, 8'h5A, 4'd0, 8'd4});
    v0 = 1'b1; d0 = 8'h5A;
    wait_out(0, 0, cyc, jap, kap, npl);
    e = sb.pop_front();
    checks++;
    if (npl !== 0) begin
      errors++; $display("FAIL same_jk: got %0d nonzero J/K cycles want 0", npl);
    end
    checks++;
    if (cyc !== int'(e.lat) || {done0, err0} !== {~e.is_err, e.is_err}) begin
      errors++; $display("FAIL same_done: got cyc=%0d d/e=%b%b want cyc=%0d", cyc, done0, err0, e.lat);
    end
    checks++;
    if (chg0 !== e.chg || bank0 !== e.bank) begin
      errors++; $display("FAIL same_result: got chg=%0d bank=%h want chg=%0d bank=%h", chg0, bank0, e.chg, e.bank);
    end
  endtask

  task automatic test_stuck_bit();
    int cyc, npl; logic [7:0] jap, kap; exp_t e;
    load_bank(0, 8'h00);
    stuck0 = 8'h08;
    sb.push_back({1'b1, 8'hF7, 4'd8, 8'd10});
    v0 = 1'b1; d0 = 8'hFF;
    wait_out(0, 0, cyc, jap, kap, npl);
    e = sb.pop_front();
    checks++;
    if (npl !== 3 || jap !== 8'hFF) begin
      errors++; $display("FAIL stuck_apply: got %0d pulses J=%h want 3 pulses J=ff", npl, jap);
    end
    checks++;
    if (cyc !== int'(e.lat) || {done0, err0} !== {~e.is_err, e.is_err}) begin
      errors++; $display("FAIL stuck_err: got cyc=%0d d/e=%b%b want cyc=%0d d/e=01", cyc, done0, err0, e.lat);
    end
    checks++;
    if (chg0 !== e.chg || bank0 !== e.bank) begin
      errors++; $display("FAIL stuck_result: got chg=%0d bank=%h want chg=%0d bank=%h", chg0, bank0, e.chg, e.bank);
    end
    stuck0 = 8'h00;
  endtask

  task automatic test_back_to_back();
    int cyc, npl; logic [7:0] jap, kap; exp_t e;
    load_bank(0, 8'h5A);
    sb.push_back({1'b0, 8'h01, 4'd5, 8'd4});
    sb.push_back({1'b0, 8'h02, 4'd2, 8'd4});
    v0 = 1'b1; d0 = 8'h01;
    @(negedge clk);
    d0 = 8'h02;
    wait_out(0, 1, cyc, jap, kap, npl);
    e = sb.pop_front();
    checks++;
    if (cyc + 1 !== int'(e.lat) || !done0 || !rdy0 || chg0 !== e.chg || bank0 !== e.bank) begin
      errors++; $display("FAIL b2b_first: got cyc=%0d done=%b rdy=%b chg=%0d bank=%h want cyc=%0d chg=%0d bank=%h",
                         cyc + 1, done0, rdy0, chg0, bank0, e.lat, e.chg, e.bank);
    end
    wait_out(0, 0, cyc, jap, kap, npl);
    e = sb.pop_front();
    checks++;
    if (cyc !== int'(e.lat) || {done0, err0} !== {~e.is_err, e.is_err}) begin
      errors++; $display("FAIL b2b_second: got cyc=%0d d/e=%b%b want cyc=%0d", cyc, done0, err0, e.lat);
    end
    checks++;
    if (chg0 !== e.chg || bank0 !== e.bank) begin
      errors++; $display("FAIL b2b_result: got chg=%0d bank=%h want chg=%0d bank=%h", chg0, bank0, e.chg, e.bank);
    end
  endtask

  task automatic test_reset_apply();
    int cyc, npl; logic [7:0] jap, kap; exp_t e; int pulses;
    load_bank(0, 8'h00);
    v0 = 1'b1; d0 = 8'h33;
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    checks++;
    if (J0 !== 8'h33) begin
      errors++; $display("FAIL rst_pre_apply: got J=%h want 33", J0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({J0, K0} !== 16'h0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL rst_apply: got J=%h K=%h busy=%b want 00 00 0", J0, K0, busy0);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done0 | err0) pulses++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done0 | err0) pulses++;
    checks++;
    if (pulses !== 0 || rdy0 !== 1'b1 || bank0 !== 8'h00) begin
      errors++; $display("FAIL rst_after: got pulses=%0d rdy=%b bank=%h want 0 1 00", pulses, rdy0, bank0);
    end
    sb.push_back({1'b0, 8'h81, 4'd2, 8'd4});
    v0 = 1'b1; d0 = 8'h81;
    wait_out(0, 0, cyc, jap, kap, npl);
    e = sb.pop_front();
    checks++;
    if (cyc !== int'(e.lat) || {done0, err0} !== {~e.is_err, e.is_err}) begin
      errors++; $display("FAIL rst_fresh_done: got cyc=%0d d/e=%b%b want cyc=%0d", cyc, done0, err0, e.lat);
    end
    checks++;
    if (chg0 !== e.chg || bank0 !== e.bank) begin
      errors++; $display("FAIL rst_fresh_result: got chg=%0d bank=%h want chg=%0d bank=%h", chg0, bank0, e.chg, e.bank);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_set_a5();
    test_mixed_dc0();
    test_mixed_dc1();
    test_same_word();
    test_stuck_bit();
    test_back_to_back();
    test_reset_apply();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
